// File: rtl/avalon_s_crossbar.sv
// NH-host x ND-device Avalon-MM crossbar.
// Per-device IDLE/GRANT arbiter; unmatched addresses complete with an error.
module avalon_s_crossbar #(
  parameter int          NH       = 2,
  parameter int          ND       = 2,
  parameter int          DW       = 32,
  parameter int          AW       = 32,
  parameter int          ARB_RR   = 1,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NH-1:0]        hosts_avn_read,
  input  logic [NH-1:0]        hosts_avn_write,
  input  logic [NH*AW-1:0]     hosts_avn_address,
  input  logic [NH*DW/8-1:0]   hosts_avn_byte_enable,
  input  logic [NH*DW-1:0]     hosts_avn_writedata,
  output logic [NH*DW-1:0]     hosts_avn_readdata,
  output logic [NH-1:0]        hosts_avn_waitrequest,
  output logic [ND-1:0]        devices_avn_read,
  output logic [ND-1:0]        devices_avn_write,
  output logic [ND*AW-1:0]     devices_avn_address,
  output logic [ND*DW/8-1:0]   devices_avn_byte_enable,
  output logic [ND*DW-1:0]     devices_avn_writedata,
  input  logic [ND*DW-1:0]     devices_avn_readdata,
  input  logic [ND-1:0]        devices_avn_waitrequest,
  input  logic [ND*AW-1:0]     devices_address_low,
  input  logic [ND*AW-1:0]     devices_address_high,
  output logic [NH-1:0]        hosts_decode_err
);

  localparam int BW  = DW / 8;
  localparam int PW  = (NH > 1) ? $clog2(NH) : 1;
  localparam int SW  = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [DW-1:0] ERR_W = DW'(ERR_DATA);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  logic [NH-1:0] w_act;
  logic [NH-1:0] w_hit;
  logic [SW-1:0] w_sel [NH];
  logic [NH-1:0] w_req [ND];
  logic [NH-1:0] w_cpl [ND];
  logic [NH-1:0] r_derr;

  assign w_act = hosts_avn_read | hosts_avn_write;

  // Descending scan so the lowest matching window is the one kept
  always_comb begin
    for (int h = 0; h < NH; h++) begin
      w_hit[h] = 1'b0;
      w_sel[h] = '0;
      for (int d = ND - 1; d >= 0; d--) begin
        if (hosts_avn_address[h*AW +: AW] >= devices_address_low[d*AW +: AW] &&
            hosts_avn_address[h*AW +: AW] <= devices_address_high[d*AW +: AW]) begin
          w_hit[h] = 1'b1;
          w_sel[h] = SW'(d);
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      for (int h = 0; h < NH; h++) begin
        w_req[d][h] = w_act[h] & w_hit[h] & (w_sel[h] == SW'(d));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_derr <= '0;
    else     r_derr <= w_act & ~w_hit & ~r_derr;
  end

  for (genvar d = 0; d < ND; d++) begin : g_dev
    state_t        r_state;
    state_t        w_next;
    logic [NH-1:0] r_grant;
    logic [NH-1:0] w_grant_n;
    logic [NH-1:0] w_pick;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_n;
    logic [PW-1:0] w_ptr_inc;
    logic          w_strobe;
    logic          w_done;
    int            w_idx;
    logic          w_rd;
    logic          w_wr;
    logic [AW-1:0] w_ad;
    logic [BW-1:0] w_be;
    logic [DW-1:0] w_wd;

    always_comb begin
      w_pick    = '0;
      w_idx     = 0;
      w_ptr_inc = '0;
      for (int i = 0; i < NH; i++) begin
        w_idx = (ARB_RR != 0) ? (int'(r_ptr) + i) % NH : i;
        if (w_pick == '0 && w_req[d][w_idx]) w_pick[w_idx] = 1'b1;
      end
      for (int h = 0; h < NH; h++) begin
        if (r_grant[h]) w_ptr_inc = PW'((h + 1) % NH);
      end
    end

    always_comb begin
      w_next    = r_state;
      w_grant_n = r_grant;
      w_ptr_n   = r_ptr;
      w_strobe  = (r_state == S_GRANT) && ((r_grant & w_act) != '0);
      w_done    = w_strobe && !devices_avn_waitrequest[d];
      unique case (r_state)
        S_IDLE: begin
          if (w_pick != '0) begin
            w_next    = S_GRANT;
            w_grant_n = w_pick;
          end
        end
        S_GRANT: begin
          if (!w_strobe || w_done) begin
            w_next    = S_IDLE;
            w_grant_n = '0;
            if (w_done && ARB_RR != 0) w_ptr_n = w_ptr_inc;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_grant <= '0;
        r_ptr   <= '0;
      end else begin
        r_state <= w_next;
        r_grant <= w_grant_n;
        r_ptr   <= w_ptr_n;
      end
    end

    always_comb begin
      w_rd = 1'b0;
      w_wr = 1'b0;
      w_ad = '0;
      w_be = '0;
      w_wd = '0;
      if (r_state == S_GRANT && !rst) begin
        for (int h = 0; h < NH; h++) begin
          if (r_grant[h]) begin
            w_rd = w_rd | hosts_avn_read[h];
            w_wr = w_wr | hosts_avn_write[h];
            w_ad = w_ad | hosts_avn_address[h*AW +: AW];
            w_be = w_be | hosts_avn_byte_enable[h*BW +: BW];
            w_wd = w_wd | hosts_avn_writedata[h*DW +: DW];
          end
        end
      end
    end

    assign devices_avn_read[d]               = w_rd;
    assign devices_avn_write[d]              = w_wr;
    assign devices_avn_address[d*AW +: AW]   = w_ad;
    assign devices_avn_byte_enable[d*BW +: BW] = w_be;
    assign devices_avn_writedata[d*DW +: DW] = w_wd;
    assign w_cpl[d] = w_done ? r_grant : '0;
  end

  always_comb begin
    hosts_avn_waitrequest = '1;
    hosts_avn_readdata    = '0;
    hosts_decode_err      = '0;
    if (!rst) begin
      for (int h = 0; h < NH; h++) begin
        if (r_derr[h]) begin
          hosts_avn_waitrequest[h]        = 1'b0;
          hosts_avn_readdata[h*DW +: DW]  = ERR_W;
          hosts_decode_err[h]             = 1'b1;
        end
        for (int d = 0; d < ND; d++) begin
          if (w_cpl[d][h]) begin
            hosts_avn_waitrequest[h]       = 1'b0;
            hosts_avn_readdata[h*DW +: DW] = devices_avn_readdata[d*DW +: DW];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_s_crossbar.sv
// Directed bench: round-robin (a) and fixed-priority (b) crossbars
// share stimulus; dev0 = 0x0000_0000..0x0000_FFFF, dev1 = 0x0001_0000..0x0001_FFFF.
module tb_avalon_s_crossbar;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  h_rd, h_wr;
  logic [63:0] h_addr, h_wd;
  logic [7:0]  h_be;
  logic [63:0] d_rdata, lo, hi;
  logic [1:0]  d_wait;

  logic [63:0] h_rdata_a, h_rdata_b;
  logic [1:0]  h_wait_a, h_wait_b, derr_a, derr_b;
  logic [1:0]  d_rd_a, d_rd_b, d_wr_a, d_wr_b;
  logic [63:0] d_addr_a, d_addr_b, d_wd_a, d_wd_b;
  logic [7:0]  d_be_a, d_be_b;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  avalon_s_crossbar #(.NH(2), .ND(2), .DW(32), .AW(32), .ARB_RR(1)) u_a (
    .clk(clk), .rst(rst),
    .hosts_avn_read(h_rd), .hosts_avn_write(h_wr),
    .hosts_avn_address(h_addr), .hosts_avn_byte_enable(h_be),
    .hosts_avn_writedata(h_wd), .hosts_avn_readdata(h_rdata_a),
    .hosts_avn_waitrequest(h_wait_a),
    .devices_avn_read(d_rd_a), .devices_avn_write(d_wr_a),
    .devices_avn_address(d_addr_a), .devices_avn_byte_enable(d_be_a),
    .devices_avn_writedata(d_wd_a), .devices_avn_readdata(d_rdata),
    .devices_avn_waitrequest(d_wait),
    .devices_address_low(lo), .devices_address_high(hi),
    .hosts_decode_err(derr_a)
  );

  avalon_s_crossbar #(.NH(2), .ND(2), .DW(32), .AW(32), .ARB_RR(0)) u_b (
    .clk(clk), .rst(rst),
    .hosts_avn_read(h_rd), .hosts_avn_write(h_wr),
    .hosts_avn_address(h_addr), .hosts_avn_byte_enable(h_be),
    .hosts_avn_writedata(h_wd), .hosts_avn_readdata(h_rdata_b),
    .hosts_avn_waitrequest(h_wait_b),
    .devices_avn_read(d_rd_b), .devices_avn_write(d_wr_b),
    .devices_avn_address(d_addr_b), .devices_avn_byte_enable(d_be_b),
    .devices_avn_writedata(d_wd_b), .devices_avn_readdata(d_rdata),
    .devices_avn_waitrequest(d_wait),
    .devices_address_low(lo), .devices_address_high(hi),
    .hosts_decode_err(derr_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  ew_a [6];
  logic [1:0]  ew_b [6];
  logic [31:0] ewd  [6];

  initial begin
    rst = 1'b1; h_rd = '0; h_wr = '0; h_addr = '0; h_wd = '0; h_be = '0;
    d_rdata = '0; d_wait = '0;
    lo = {32'h0001_0000, 32'h0000_0000};
    hi = {32'h0001_FFFF, 32'h0000_FFFF};
    ew_a = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
    ew_b = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    ewd  = '{32'h0, 32'hAAAA_0000, 32'h0, 32'hBBBB_1111, 32'h0, 32'hAAAA_0000};

    @(negedge clk);
    chk("rst_wait", h_wait_a, 2'b11);
    chk("rst_drd", d_rd_a, 0);
    chk("rst_rdata", h_rdata_a, 0);
    chk("rst_derr", derr_a, 0);
    tick(); rst = 1'b0;

    // single read
    tick(); h_rd = 2'b01; h_addr[31:0] = 32'h10;
    d_rdata = {32'h0, 32'h1234_5678}; d_wait = 2'b00;
    @(negedge clk);
    chk("rd_t_wait", h_wait_a, 2'b11);
    chk("rd_t_drd", d_rd_a, 0);
    chk("rd_t_rdata", h_rdata_a, 0);
    tick(); @(negedge clk);
    chk("rd_t1_drd", d_rd_a, 2'b01);
    chk("rd_t1_addr", d_addr_a[31:0], 32'h10);
    chk("rd_t1_wait", h_wait_a, 2'b10);
    chk("rd_t1_rdata", h_rdata_a[31:0], 32'h1234_5678);
    tick(); h_rd = 2'b00; @(negedge clk);
    chk("rd_t2_wait", h_wait_a, 2'b11);
    chk("rd_t2_rdata", h_rdata_a, 0);

    // contention on dev1
    tick(); h_wr = 2'b11;
    h_addr = {32'h0001_0008, 32'h0001_0004};
    h_wd = {32'hBBBB_1111, 32'hAAAA_0000}; h_be = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rr_wait_c%0d", c), h_wait_a, ew_a[c]);
      chk($sformatf("rr_wd_c%0d", c), d_wd_a[63:32], ewd[c]);
      chk($sformatf("rr_dwr_c%0d", c), d_wr_a, (c % 2 == 1) ? 2'b10 : 2'b00);
      chk($sformatf("fp_wait_c%0d", c), h_wait_b, ew_b[c]);
      chk($sformatf("fp_wd_c%0d", c), d_wd_b[63:32],
          (c % 2 == 1) ? 32'hAAAA_0000 : 32'h0);
      tick();
    end
    h_wr = 2'b00;

    // decode error
    tick(); h_rd = 2'b10; h_addr[63:32] = 32'h0002_0000;
    @(negedge clk);
    chk("de_t_wait", h_wait_a, 2'b11);
    chk("de_t_err", derr_a, 0);
    tick(); @(negedge clk);
    chk("de_t1_wait", h_wait_a, 2'b01);
    chk("de_t1_rdata", h_rdata_a[63:32], 32'hDEAD_BEEF);
    chk("de_t1_err", derr_a, 2'b10);
    chk("de_t1_drd", d_rd_a, 0);
    chk("de_t1_err_b", derr_b, 2'b10);
    tick(); h_rd = 2'b00; @(negedge clk);
    chk("de_t2_err", derr_a, 0);
    chk("de_t2_wait", h_wait_a, 2'b11);

    // concurrency with dev1 stall
    tick(); h_rd = 2'b01; h_wr = 2'b10;
    h_addr = {32'h0001_0100, 32'h0000_0100};
    d_wait = 2'b10; d_rdata = {32'h0, 32'hCAFE_0001};
    @(negedge clk);
    chk("cc_t_wait", h_wait_a, 2'b11);
    tick(); @(negedge clk);
    chk("cc_t1_wait", h_wait_a, 2'b10);
    chk("cc_t1_drd", d_rd_a, 2'b01);
    chk("cc_t1_dwr", d_wr_a, 2'b10);
    chk("cc_t1_rdata", h_rdata_a[31:0], 32'hCAFE_0001);
    tick(); h_rd = 2'b00; @(negedge clk);
    chk("cc_t2_wait", h_wait_a, 2'b11);
    tick(); @(negedge clk);
    chk("cc_t3_wait", h_wait_a, 2'b11);
    chk("cc_t3_dwr", d_wr_a, 2'b10);
    tick(); d_wait = 2'b00; @(negedge clk);
    chk("cc_t4_wait", h_wait_a, 2'b01);
    tick(); h_wr = 2'b00;

    // reset during a stalled grant
    tick(); h_rd = 2'b01; h_addr[31:0] = 32'h200; d_wait = 2'b01;
    @(negedge clk);
    chk("rm_t_drd", d_rd_a, 0);
    tick(); @(negedge clk);
    chk("rm_t1_drd", d_rd_a, 2'b01);
    chk("rm_t1_wait", h_wait_a, 2'b11);
    tick(); rst = 1'b1; @(negedge clk);
    chk("rm_rst_drd", d_rd_a, 0);
    chk("rm_rst_wait", h_wait_a, 2'b11);
    tick(); rst = 1'b0; @(negedge clk);
    chk("rm_arb_drd", d_rd_a, 0);
    tick(); d_wait = 2'b00; @(negedge clk);
    chk("rm_grant_drd", d_rd_a, 2'b01);
    chk("rm_grant_wait", h_wait_a, 2'b10);
    tick(); h_rd = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
